// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect stage.
// State codes, instruction geometry and immediate field slice.
package fetch_redirect_unit_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_e;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_REQ   = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_VALID = 2'd3;

  localparam int unsigned INST_BYTES   = 2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned IMM_W_DEF = 8;

endpackage

// File: rtl/fetch_redirect_unit_adder.sv
// Branch target: br_pc + one instruction + offset scaled to bytes.
// Pure combinational so execute can share the same block.
module branch_target_adder
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] br_pc_i,
  input  logic [W-1:0] br_offset_i,
  output logic [W-1:0] target_o
);

  logic [W-1:0] off_bytes;

  // Offset counts instructions; the top bit is lost in the
  // shift, which is the intended mod-2^W behaviour.
  assign off_bytes = {br_offset_i[W-2:0], 1'b0};
  assign target_o  = br_pc_i + W'(INST_BYTES) + off_bytes;

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC generation and single-outstanding instruction fetch
// with execute-driven redirect and in-flight squash.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int unsigned        DATA_W   = 16,
  parameter logic [DATA_W-1:0]  RESET_PC = RESET_PC_DEF,
  parameter int unsigned        IMM_W    = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_pc,
  output logic [IMM_W-1:0]  imm8,
  input  logic              inst_ready,
  input  logic              br_valid,
  input  logic [DATA_W-1:0] br_pc,
  input  logic [DATA_W-1:0] br_offset,
  output logic [DATA_W-1:0] pc
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  inst_q, inst_d;
  logic [DATA_W-1:0]  ipc_q, ipc_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;

  logic [DATA_W-1:0]  br_target;
  logic [DATA_W-1:0]  pc_seq;

  branch_target_adder #(
    .W (DATA_W)
  ) u_bta (
    .br_pc_i     (br_pc),
    .br_offset_i (br_offset),
    .target_o    (br_target)
  );

  assign pc_seq = pc_q + DATA_W'(INST_BYTES);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (br_valid) pc_d = br_target;
        if (!halt) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_gnt) begin
          addr_d  = pc_q;
          pc_d    = pc_seq;
          state_d = ST_WAIT;
          drop_d  = br_valid;
        end
        if (br_valid) pc_d = br_target;
      end
      ST_WAIT: begin
        if (br_valid) pc_d = br_target;
        if (imem_rvalid) begin
          drop_d = 1'b0;
          // Same-cycle redirect discards the word directly.
          if (drop_q || br_valid) begin
            state_d = ST_REQ;
          end else begin
            inst_d  = imem_rdata;
            ipc_d   = addr_q;
            imm_d   = imem_rdata[IMM_LSB +: IMM_W];
            valid_d = 1'b1;
            state_d = ST_VALID;
          end
        end else if (br_valid) begin
          drop_d = 1'b1;
        end
      end
      ST_VALID: begin
        if (br_valid) pc_d = br_target;
        if (br_valid || inst_ready) begin
          valid_d = 1'b0;
          state_d = halt ? ST_IDLE : ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = imem_req ? pc_q : '0;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign imm8       = imm_q;
  assign pc         = pc_q;

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
Program-counter and instruction-fetch stage directly upstream of the 8-to-16-bit sign extender. Issues fetches over a req/gnt/rvalid memory handshake and hands each instruction, its PC and its raw 8-bit immediate field (inst[7:0], the sign extender's input) to decode. Consumes the sign-extended branch offset returned from execute to redirect the PC.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
DATA_W, 16, instruction and address width.
IMM_W, 8, immediate field width, always inst[IMM_W-1:0].

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  reset; one clock, synchronous, active-low.
halt  in  1  level; no new fetch requests issued while high.
imem_req  out  1  fetch request; held high until granted.
imem_addr  out  16  fetch address, stable while imem_req high.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  read data valid; exactly one per grant, at least 1 cycle after gnt.
imem_rdata  in  16  instruction word.
inst_valid  out  1  decode output valid.
inst  out  16  instruction word.
inst_pc  out  16  address of inst.
imm8  out  8  inst[7:0], raw, unextended.
inst_ready  in  1  decode accepts when inst_valid and inst_ready both high.
br_valid  in  1  one-cycle redirect pulse from execute.
br_pc  in  16  PC of the taken branch.
br_offset  in  16  sign-extended 16-bit offset, in instructions.
pc  out  16  next fetch address (debug/visibility).

Behaviour:
- Reset (rst_n low at a clock edge): pc=RESET_PC, state=IDLE, imem_req=0, inst_valid=0, inst/inst_pc/imm8=0, drop flag=0. Reset mid-transaction abandons it; a late imem_rvalid arriving in IDLE after reset is ignored.
- Byte addressing, 16-bit instructions: sequential pc += 2. Redirect target = br_pc + 2 + (br_offset << 1), truncated mod 2^16. Wrap-around at 16'hFFFE -> 16'h0000 is legal, not flagged.
- States: IDLE -> REQ when halt=0. REQ: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT, pc += 2. WAIT: on imem_rvalid capture inst=imem_rdata, inst_pc=addr of that fetch, imm8=imem_rdata[7:0], inst_valid=1 -> VALID. VALID: on handshake, inst_valid=0 and -> REQ (halt=0) or IDLE (halt=1) in the same cycle.
- Best-case throughput: one instruction every 3 cycles (REQ, WAIT, VALID) with gnt immediate and rvalid next cycle. No prefetch buffer.
- inst/inst_pc/imm8 stable while inst_valid=1 and inst_ready=0.
- br_valid (highest priority except reset): pc=target next cycle; inst_valid cleared in the same cycle (any pending output squashed, even if inst_ready=1 that cycle).
  - In IDLE/VALID: -> REQ (or IDLE if halt).
  - In REQ without gnt that cycle: imem_req stays high, imem_addr becomes target next cycle (address change allowed only on redirect).
  - In REQ with gnt same cycle, or in WAIT: set drop flag; the next imem_rvalid is discarded, then -> REQ at target.
  - br_valid and imem_rvalid in same WAIT cycle: that data discarded, no drop flag set.
- halt: only gates IDLE->REQ and VALID->REQ; an outstanding request/response always completes.
- pc output = register value; imem_addr = pc while in REQ, 0 otherwise.

Decomposition:
- Shared package: state enum (IDLE, REQ, WAIT, VALID), INST_BYTES=2, RESET_PC default, imm field slice constants.
- One sub-module: branch_target_adder (br_pc, br_offset -> 16-bit target), combinational, reusable by execute.

Test Plan:
- Reset then run, gnt immediate, rvalid +1, inst_ready=1: addresses 0000,0002,0004; inst_valid every 3rd cycle; imm8 = rdata[7:0].
- Backpressure: inst_ready=0 for 5 cycles with inst=16'hA5F0 -> inst, inst_pc, imm8=8'hF0 held constant; no new imem_req.
- Redirect in VALID: br_pc=0010, br_offset=FFFC -> next imem_addr=000A; held instruction squashed.
- Redirect in WAIT: br_pc=0020, br_offset=0003 -> returning data dropped, next fetch 0028, no inst_valid for dropped word.
- Wrap: RESET_PC=FFFE -> fetches FFFE then 0000; br_pc=FFF0, br_offset=0010 -> target 0012.
- rst_n low during WAIT, rvalid arrives after -> ignored; fetch restarts at RESET_PC, inst_valid stays 0.
